stream_req_gen: RTL

STREAM_REQ_GEN -- requirements
Module: stream_req_gen

---
 rtl/stream_req_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stream_req_gen.sv
// Multi-stream cacheline request generator: per-stream EA/count state, round-robin arbitration, registered request output.
// Optional per-stream credit gating is enabled by defining STREAM_REQ_GEN_CRD_EN.
`timescale 1ns/1ps

module stream_req_gen #(
    parameter int addr_width = 64,
    parameter int nstrms     = 64,
    parameter int cnt_width  = 16,
    parameter int crd_max    = 4,
    localparam int nstrms_width = $clog2(nstrms),
    localparam int crd_width    = $clog2(crd_max + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_cmd_v,
    output logic                    i_cmd_r,
    input  logic [nstrms_width-1:0] i_cmd_sid,
    input  logic [addr_width-1:0]   i_cmd_ea,
    input  logic [cnt_width-1:0]    i_cmd_cnt,
    input  logic                    i_crd_v,
    input  logic [nstrms_width-1:0] i_crd_sid,
    output logic                    o_req_v,
    input  logic                    o_req_r,
    output logic [nstrms_width-1:0] o_req_sid,
    output logic [addr_width-1:0]   o_req_ea,
    output logic                    o_busy,
    output logic                    o_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and payload holds while valid is high and ready is low.
    // i_crd_v has no ready and is consumed every cycle it is high.

    logic [nstrms-1:0]     active_q;
    logic [addr_width-1:0] ea_q  [nstrms];
    logic [cnt_width-1:0]  rem_q [nstrms];
    logic [nstrms_width-1:0] rr_ptr_q;

    logic [nstrms-1:0]       elig;
    logic                    win_v;
    logic [nstrms_width-1:0] win_sid;
    logic                    load;
    logic                    cmd_acc;
    int                      idx;

`ifdef STREAM_REQ_GEN_CRD_EN
    logic [crd_width-1:0] crd_q [nstrms];
    logic [nstrms-1:0]    crd_inc;
    logic [nstrms-1:0]    crd_dec;
    logic                 err_q;
`else
    logic                 unused_crd;
`endif

    assign i_cmd_r = ~active_q[i_cmd_sid];
    assign cmd_acc = i_cmd_v & i_cmd_r;
    assign o_busy  = |active_q;
    // The output stage only takes a new winner when it is empty or being drained this cycle.
    assign load    = win_v & (~o_req_v | o_req_r);

    always_comb begin
        elig = '0;
        for (int i = 0; i < nstrms; i++) begin
`ifdef STREAM_REQ_GEN_CRD_EN
            elig[i] = active_q[i] & (rem_q[i] != '0) & (crd_q[i] != '0);
`else
            elig[i] = active_q[i] & (rem_q[i] != '0);
`endif
        end
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        win_v   = 1'b0;
        win_sid = '0;
        idx     = 0;
        for (int k = 1; k <= nstrms; k++) begin
            idx = (int'(rr_ptr_q) + k) % nstrms;
            if (!win_v && elig[idx]) begin
                win_v   = 1'b1;
                win_sid = nstrms_width'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= '0;
            for (int i = 0; i < nstrms; i++) begin
                ea_q[i]  <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            if (load) begin
                ea_q[win_sid]  <= ea_q[win_sid] + addr_width'(128);
                rem_q[win_sid] <= rem_q[win_sid] - cnt_width'(1);
                if (rem_q[win_sid] == cnt_width'(1))
                    active_q[win_sid] <= 1'b0;
            end
            // An accepted command always targets an inactive stream, so it never collides with the load.
            if (cmd_acc && i_cmd_cnt != '0) begin
                active_q[i_cmd_sid] <= 1'b1;
                ea_q[i_cmd_sid]     <= i_cmd_ea & ~addr_width'(127);
                rem_q[i_cmd_sid]    <= i_cmd_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req_v   <= 1'b0;
            o_req_sid <= '0;
            o_req_ea  <= '0;
            rr_ptr_q  <= nstrms_width'(nstrms - 1);
        end else if (!o_req_v || o_req_r) begin
            o_req_v <= win_v;
            if (win_v) begin
                o_req_sid <= win_sid;
                o_req_ea  <= ea_q[win_sid];
                rr_ptr_q  <= win_sid;
            end
        end
    end

`ifdef STREAM_REQ_GEN_CRD_EN
    always_comb begin
        crd_inc = '0;
        crd_dec = '0;
        for (int i = 0; i < nstrms; i++) begin
            crd_inc[i] = i_crd_v & (i_crd_sid == nstrms_width'(i));
            crd_dec[i] = load & (win_sid == nstrms_width'(i));
        end
    end

    // A return and a load on the same stream cancel; a return at full credit is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            for (int i = 0; i < nstrms; i++)
                crd_q[i] <= crd_width'(crd_max);
        end else begin
            for (int i = 0; i < nstrms; i++) begin
                if (crd_inc[i] && !crd_dec[i]) begin
                    if (crd_q[i] == crd_width'(crd_max))
                        err_q <= 1'b1;
                    else
                        crd_q[i] <= crd_q[i] + crd_width'(1);
                end else if (crd_dec[i] && !crd_inc[i]) begin
                    crd_q[i] <= crd_q[i] - crd_width'(1);
                end
            end
        end
    end

    assign o_err = err_q;
`else
    assign unused_crd = ^{i_crd_v, i_crd_sid};
    assign o_err      = 1'b0;
`endif

endmodule
